// File: rtl/spi_target_pkg.sv
// Shared command-byte layout and FSM state encoding for the SPI register target.
package spi_target_pkg;
  localparam int unsigned CMD_DIR_BIT  = 1;
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} spi_state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// on the synchronized value.
module spi_pin_sync
  import spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target exposing a register file, plus a parallel local port.
// Define SPI_TARGET_STATUS_EN to add status_in, echoed on MISO during the command byte.
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  input  logic              loc_we,
  output logic [7:0]        loc_rdata,
  output logic              spi_wr_pulse,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]        spi_wr_data,
  output logic              busy
`ifdef SPI_TARGET_STATUS_EN
  ,
  input  logic [7:0]        status_in
`endif
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic unused_edges;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .pin(spi_sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .pin(spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .pin(spi_ss_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  assign unused_edges = ^{sclk_sync, mosi_rise, mosi_fall, ss_rise};

  logic [7:0]  regs [0:DEPTH-1];
  spi_state_t  state, state_next;
  logic [2:0]  bitcnt, bitcnt_next;
  logic [7:0]  shift_in, shift_in_next;
  logic [7:0]  shift_out, shift_out_next;
  logic [ADDR_W-1:0] addr, addr_next, addr_inc, cmd_addr;
  logic        dir, dir_next;
  logic        miso_next, oe_next;
  logic        commit;
  logic [7:0]  byte_in;
  logic [7:0]  status_init;

`ifdef SPI_TARGET_STATUS_EN
  assign status_init = status_in;
`else
  assign status_init = '0;
`endif

  assign byte_in  = {shift_in[6:0], mosi_sync};
  assign cmd_addr = ADDR_W'(byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB]);
  assign addr_inc = addr + ADDR_W'(1);
  assign busy     = ~ss_sync;

  always_comb begin
    state_next     = state;
    bitcnt_next    = bitcnt;
    shift_in_next  = shift_in;
    shift_out_next = shift_out;
    addr_next      = addr;
    dir_next       = dir;
    miso_next      = spi_miso;
    oe_next        = spi_miso_oe;
    commit         = 1'b0;
    if (ss_sync) begin
      state_next = ST_IDLE;
      oe_next    = 1'b0;
      miso_next  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // First command bit goes out with the select edge, ahead of any SCLK rise.
          if (ss_fall) begin
            state_next     = ST_CMD;
            bitcnt_next    = '0;
            oe_next        = 1'b1;
            miso_next      = status_init[7];
            shift_out_next = {status_init[6:0], 1'b0};
          end
        end
        ST_CMD, ST_DATA: begin
          if (sclk_rise) begin
            shift_in_next = byte_in;
            bitcnt_next   = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (state == ST_CMD) begin
                state_next     = ST_DATA;
                addr_next      = cmd_addr;
                dir_next       = byte_in[CMD_DIR_BIT];
                shift_out_next = byte_in[CMD_DIR_BIT] ? '0 : regs[cmd_addr];
              end else begin
                addr_next = addr_inc;
                if (dir) commit = 1'b1;
                else     shift_out_next = regs[addr_inc];
              end
            end
          end else if (sclk_fall) begin
            miso_next      = shift_out[7];
            shift_out_next = {shift_out[6:0], 1'b0};
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bitcnt       <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      dir          <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      spi_wr_pulse <= 1'b0;
      spi_wr_addr  <= '0;
      spi_wr_data  <= '0;
    end else begin
      state        <= state_next;
      bitcnt       <= bitcnt_next;
      shift_in     <= shift_in_next;
      shift_out    <= shift_out_next;
      addr         <= addr_next;
      dir          <= dir_next;
      spi_miso     <= miso_next;
      spi_miso_oe  <= oe_next;
      spi_wr_pulse <= commit;
      if (commit) begin
        spi_wr_addr <= addr;
        spi_wr_data <= byte_in;
      end
    end
  end

  // SPI commit has priority over a local write to the same address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      loc_rdata <= '0;
    end else begin
      if (loc_we && !(commit && (loc_addr == addr))) regs[loc_addr] <= loc_wdata;
      if (commit) regs[addr] <= byte_in;
      loc_rdata <= regs[loc_addr];
    end
  end

endmodule

// File: doc/spi_target_regs.md
Name: spi_target_regs

Overview:
- SPI mode-0 target (slave) that answers the SoC's SPI master (MOSI/SCLK/SS_n out, MISO in), i.e. the far end of the spi0 link.
- Exposes a 32 x 8-bit register file to the SPI master and a parallel local port to fabric logic.
- Everything runs on the system clock; SPI pins are oversampled, which requires SCLK <= clk/8.
- Wire format: command byte then data bytes, with the address auto-incrementing after each data byte.

Parameters:
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- SYNC_STAGES, 2, synchronizer flops on sclk/mosi/ss_n (min 2).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock from master, idle low.
- spi_mosi  in  1  master-out data.
- spi_ss_n  in  1  active-low select.
- spi_miso  out  1  target-out data.
- spi_miso_oe  out  1  MISO drive enable; the top level tristates MISO when this is 0.
- loc_addr  in  ADDR_W  local port address.
- loc_wdata  in  8  local write data.
- loc_we  in  1  local write strobe.
- loc_rdata  out  8  local read data, registered, 1-cycle latency.
- spi_wr_pulse  out  1  one-cycle pulse when an SPI data byte is committed.
- spi_wr_addr  out  ADDR_W  address of the committed byte, held until the next commit.
- spi_wr_data  out  8  data of the committed byte, held until the next commit.
- busy  out  1  high while a transaction is in progress (ss_n sync low).

Behaviour:
- Reset values: all registers 0; spi_miso=0; spi_miso_oe=0; loc_rdata=0; spi_wr_pulse=0; spi_wr_addr=0; spi_wr_data=0; busy=0; FSM in IDLE.
- Synchronization: sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - Rise = sync sclk 0->1; fall = sync sclk 1->0.
  - Pin-to-internal latency is SYNC_STAGES+1 cycles.
- Command byte, MSB first:
  - [7:3] start address (only the low ADDR_W bits are used; bits above ADDR_W are ignored).
  - [2] reserved.
  - [1] dir: 1 = write, 0 = read.
  - [0] reserved.
- FSM states:
  - IDLE: on ss_n falling edge go to CMD; bitcnt=0; spi_miso_oe=1.
  - CMD: shift mosi in on each rise, bitcnt++. On the 8th rise, latch addr and dir and go to DATA.
    - Read: load shift_out = reg[addr].
    - Write: shift_out = 0.
  - DATA: shift mosi in on each rise, drive shift_out MSB on each fall.
    - On the 8th rise of a write byte: reg[addr] <= shifted byte; pulse spi_wr_pulse.
    - On the 8th rise of a read byte: load shift_out = reg[addr+1].
    - Then addr <= addr+1, wrapping modulo 2**ADDR_W (31 -> 0). Stay in DATA.
  - Any state: ss_n sync high -> IDLE next cycle; spi_miso_oe=0; partial byte discarded with no write and no pulse.
- Mode 0 timing: MISO changes only on fall. The first bit of each byte is valid before the first rise of that byte.
  - During CMD, MISO outputs 0 unless SPI_TARGET_STATUS_EN is defined.
- Local port:
  - loc_we writes reg[loc_addr] on the clock edge.
  - loc_rdata <= reg[loc_addr] every cycle.
- Write collision: if an SPI commit and loc_we target the same address in the same cycle, the SPI write wins and the local write is dropped. Different addresses both commit.
- A read byte samples the register at load time; later local writes do not alter bits already in flight.
- busy = ~ss_n_sync.
- Reset asserted mid-transaction aborts it immediately. After reset release, the FSM waits for a fresh ss_n falling edge.

Optional Feature:
- Macro SPI_TARGET_STATUS_EN.
- When defined: adds input status_in[7:0]. It is captured into shift_out on the ss_n falling edge and shifted out on MISO during the command byte (MAX3421E-style status echo).
- When undefined: the port is absent and MISO is 0 for all command-byte bits.

Decomposition:
- Package spi_target_pkg holds:
  - localparams CMD_DIR_BIT=1, CMD_ADDR_MSB=7, CMD_ADDR_LSB=3.
  - typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} spi_state_t.
- One sub-module, spi_pin_sync: a parameterized SYNC_STAGES synchronizer plus rise/fall edge detector, instantiated for sclk and ss_n (and sync-only for mosi).

Test Plan:
- Reset then idle -> all outputs 0; spi_miso_oe=0; loc_rdata=0 one cycle after reset release.
- SPI write: cmd 0x1A (addr 3, write) then data 0xA5 -> spi_wr_pulse for 1 cycle with addr=3, data=0xA5. A local read of addr 3 then returns 0xA5.
- Burst read with wrap: local writes reg31=0x11, reg0=0x22. SPI cmd 0xF8 (addr 31, read), then two bytes -> MISO returns 0x11 then 0x22.
- Abort: ss_n raised after 5 bits of a write data byte -> no write, no pulse, spi_miso_oe=0. The next transaction decodes correctly.
- Collision: SPI commit to addr 5 (0x3C) in the same cycle as loc_we to addr 5 (0x99) -> reg5=0x3C.
- With SPI_TARGET_STATUS_EN and status_in=0xC3 at the ss_n fall -> MISO shows 1,1,0,0,0,0,1,1 during the command byte.
